// File: rtl/tmds_rx_channel.sv
// tmds_rx_channel: aligns raw deserialized 10-bit words using control-token runs
// and decodes the aligned TMDS symbols into pixel data or control bits.
module tmds_rx_channel #(
    parameter int unsigned CTRL_RUN   = 16,
    parameter int unsigned SEARCH_LEN = 2048
) (
    input  logic       clk_pix,
    input  logic       rst_pix,
    input  logic [9:0] tmds_in,
    output logic       de,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       locked,
    output logic [3:0] offset
);

    localparam int unsigned SYM_W = 10;
    localparam int unsigned WIN_W = 2 * SYM_W;
    localparam int unsigned OFF_W = 4;
    localparam int unsigned WD_W  = $clog2(SEARCH_LEN) + 1;
    localparam int unsigned RUN_W = $clog2(CTRL_RUN) + 1;

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [SYM_W-1:0] TOK_00 = 10'b1101010100;
    localparam logic [SYM_W-1:0] TOK_01 = 10'b0010101011;
    localparam logic [SYM_W-1:0] TOK_10 = 10'b0101010100;
    localparam logic [SYM_W-1:0] TOK_11 = 10'b1010101011;

    localparam logic [WD_W-1:0]  WD_LAST     = WD_W'(SEARCH_LEN - 1);
    localparam logic [RUN_W-1:0] RUN_MAX     = RUN_W'(CTRL_RUN);
    localparam logic [RUN_W-1:0] RUN_HIT_MIN = RUN_W'(CTRL_RUN - 1);
    localparam logic [OFF_W-1:0] OFF_LAST    = OFF_W'(9);

    logic [SYM_W-1:0] prev_q,   prev_d;
    logic [SYM_W-1:0] sym_q,    sym_d;
    logic [0:0]       state_q,  state_d;
    logic [OFF_W-1:0] offset_q, offset_d;
    logic [RUN_W-1:0] run_q,    run_d;
    logic [WD_W-1:0]  wd_q,     wd_d;
    logic             de_q,     de_d;
    logic [7:0]       data_q,   data_d;
    logic [1:0]       ctrl_q,   ctrl_d;

    logic [WIN_W-1:0] window;
    logic             is_tok;
    logic [1:0]       tok_val;
    logic [7:0]       dq;
    logic [7:0]       dec;
    logic             run_hit;
    logic             expiry;
    logic [OFF_W-1:0] offset_next;

    // Two-word window; prev sits in the low half so offset 0 passes prev through.
    always_comb begin
        window = {tmds_in, prev_q};
        prev_d = tmds_in;
        sym_d  = SYM_W'(window >> offset_q);
    end

    always_comb begin
        is_tok  = 1'b1;
        tok_val = 2'b00;
        case (sym_q)
            TOK_00:  tok_val = 2'b00;
            TOK_01:  tok_val = 2'b01;
            TOK_10:  tok_val = 2'b10;
            TOK_11:  tok_val = 2'b11;
            default: is_tok  = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    always_comb begin
        dq     = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
        dec    = 8'h00;
        dec[0] = dq[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = sym_q[8] ? (dq[i] ^ dq[i-1]) : ~(dq[i] ^ dq[i-1]);
        end
    end

    always_comb begin
        run_hit     = is_tok && (run_q >= RUN_HIT_MIN);
        expiry      = (wd_q == WD_LAST);
        offset_next = (offset_q == OFF_LAST) ? OFF_W'(0) : offset_q + OFF_W'(1);
    end

    // Next-state: a run hit always takes priority over a watchdog expiry.
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        wd_d     = wd_q + WD_W'(1);
        run_d    = '0;
        if (is_tok) begin
            run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
        end
        if (run_hit) begin
            state_d = ST_LOCKED;
            wd_d    = '0;
        end else if (expiry) begin
            state_d  = ST_SEARCH;
            offset_d = offset_next;
            wd_d     = '0;
            run_d    = '0;
        end
    end

    // Decoded outputs are held at zero until the channel is locked.
    always_comb begin
        de_d   = 1'b0;
        data_d = 8'h00;
        ctrl_d = 2'b00;
        if (state_q == ST_LOCKED) begin
            if (is_tok) begin
                ctrl_d = tok_val;
            end else begin
                de_d   = 1'b1;
                data_d = dec;
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            prev_q   <= '0;
            sym_q    <= '0;
            state_q  <= ST_SEARCH;
            offset_q <= '0;
            run_q    <= '0;
            wd_q     <= '0;
            de_q     <= 1'b0;
            data_q   <= 8'h00;
            ctrl_q   <= 2'b00;
        end else begin
            prev_q   <= prev_d;
            sym_q    <= sym_d;
            state_q  <= state_d;
            offset_q <= offset_d;
            run_q    <= run_d;
            wd_q     <= wd_d;
            de_q     <= de_d;
            data_q   <= data_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign de     = de_q;
    assign data   = data_q;
    assign ctrl   = ctrl_q;
    assign locked = (state_q == ST_LOCKED);
    assign offset = offset_q;

endmodule

// File: tb/tb_tmds_rx_channel.sv
// Bench for tmds_rx_channel: random/directed word streams, a symbol-level
// reference model feeding a scoreboard queue, and a decoupled output monitor.
module tb_tmds_rx_channel;

    localparam int unsigned CTRL_RUN   = 16;
    localparam int unsigned SEARCH_LEN = 64;
    localparam logic [9:0]  TOKS [4]   = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    logic       clk_pix = 1'b0;
    logic       rst_pix;
    logic [9:0] tmds_in;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       locked;
    logic [3:0] offset;

    always #5 clk_pix = ~clk_pix;

    tmds_rx_channel #(.CTRL_RUN(CTRL_RUN), .SEARCH_LEN(SEARCH_LEN)) dut (
        .clk_pix (clk_pix),
        .rst_pix (rst_pix),
        .tmds_in (tmds_in),
        .de      (de),
        .data    (data),
        .ctrl    (ctrl),
        .locked  (locked),
        .offset  (offset)
    );

    typedef struct packed {
        logic       de;
        logic [7:0] data;
        logic [1:0] ctrl;
        logic       locked;
        logic [3:0] offset;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state, kept at symbol/run level.
    logic [9:0] m_prev = '0;
    logic [9:0] m_sym  = '0;
    bit         m_locked = 1'b0;
    int         m_off   = 0;
    int         m_run   = 0;
    int         m_since = 0;
    obs_t       m_out   = '0;

    function automatic int token_index(input logic [9:0] s);
        for (int k = 0; k < 4; k++) if (TOKS[k] == s) return k;
        return -1;
    endfunction

    // Forward TMDS data encoding (transition stage plus optional inversion).
    function automatic logic [9:0] tmds_encode(input logic [7:0] d, input logic use_xor,
                                               input logic inv);
        logic [7:0] qm;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xor ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
        return {inv, use_xor, inv ? ~qm : qm};
    endfunction

    // Decode by searching for the byte whose encoding reproduces the symbol.
    function automatic logic [7:0] tmds_data(input logic [9:0] s);
        for (int v = 0; v < 256; v++)
            if (tmds_encode(8'(v), s[8], s[9]) == s) return 8'(v);
        return 8'h00;
    endfunction

    function automatic logic [9:0] pick(input logic [9:0] cur, input logic [9:0] old,
                                        input int off);
        logic [19:0] serial;
        logic [9:0]  s;
        serial = {cur, old};
        for (int b = 0; b < 10; b++) s[b] = serial[off + b];
        return s;
    endfunction

    task automatic model_step(input logic [9:0] w, input bit rst);
        int         tk;
        bit         hit;
        bit         expire;
        logic [9:0] nsym;
        if (rst) begin
            m_prev = '0; m_sym = '0; m_locked = 1'b0;
            m_off = 0; m_run = 0; m_since = 0; m_out = '0;
            return;
        end
        nsym   = pick(w, m_prev, m_off);
        tk     = token_index(m_sym);
        hit    = (tk >= 0) && (m_run + 1 >= int'(CTRL_RUN));
        expire = (m_since == int'(SEARCH_LEN) - 1);
        m_out.de   = m_locked && (tk < 0);
        m_out.data = (m_locked && tk < 0) ? tmds_data(m_sym) : 8'h00;
        m_out.ctrl = (m_locked && tk >= 0) ? 2'(tk) : 2'b00;
        m_run   = (tk >= 0) ? ((m_run + 1 > int'(CTRL_RUN)) ? int'(CTRL_RUN) : m_run + 1) : 0;
        m_since = m_since + 1;
        if (hit) begin
            m_locked = 1'b1;
            m_since  = 0;
        end else if (expire) begin
            m_locked = 1'b0;
            m_off    = (m_off + 1) % 10;
            m_since  = 0;
            m_run    = 0;
        end
        m_sym  = nsym;
        m_prev = w;
        m_out.locked = m_locked;
        m_out.offset = 4'(m_off);
    endtask

    task automatic drive(input logic [9:0] w, input bit rst);
        @(negedge clk_pix);
        tmds_in = w;
        rst_pix = rst;
        model_step(w, rst);
        exp_q.push_back(m_out);
    endtask

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        do w = 10'($urandom); while (token_index(w) >= 0);
        return w;
    endfunction

    function automatic logic [9:0] rand_tok();
        return TOKS[$urandom_range(0, 3)];
    endfunction

    // Monitor: one expected entry per clock, compared just after the edge.
    initial begin : monitor
        obs_t got;
        obs_t want;
        forever begin
            @(posedge clk_pix);
            #1;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = {de, data, ctrl, locked, offset};
                n_cmp++;
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL scoreboard t=%0t: got de=%0b data=%02h ctrl=%0d locked=%0b offset=%0d, expected de=%0b data=%02h ctrl=%0d locked=%0b offset=%0d",
                             $time, got.de, got.data, got.ctrl, got.locked, got.offset,
                             want.de, want.data, want.ctrl, want.locked, want.offset);
                end
            end
        end
    end

    initial begin : timeout
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        bit sb[$];
        int sym_n;
        int cyc;
        int guard;
        logic [9:0] w;
        logic [9:0] s;

        tmds_in = '0;
        rst_pix = 1'b1;

        for (int i = 0; i < 5; i++) drive(10'($urandom), 1'b1);

        // Aligned lock, then the two single-level data words.
        for (int i = 0; i < 20; i++) drive(TOKS[0], 1'b0);
        drive(10'h100, 1'b0);
        drive(10'h200, 1'b0);
        drive(TOKS[0], 1'b0);
        @(posedge clk_pix); #2;
        check("first_data_00", {23'd0, de, data}, {23'd0, 1'b1, 8'h00});
        drive(TOKS[0], 1'b0);
        @(posedge clk_pix); #2;
        check("second_data_ff", {23'd0, de, data}, {23'd0, 1'b1, 8'hFF});

        for (int k = 0; k < 4; k++) drive(TOKS[k], 1'b0);
        for (int i = 0; i < 18; i++) drive(TOKS[0], 1'b0);

        // Random blanking/active blocks short enough to keep lock.
        for (int blk = 0; blk < 6; blk++) begin
            for (int i = 0; i < 20; i++) drive(rand_tok(), 1'b0);
            for (int i = 0; i < 30; i++) drive(rand_data(), 1'b0);
        end
        @(posedge clk_pix); #2;
        check("locked_aligned", int'(locked), 1);
        check("offset_aligned", int'(offset), 0);

        // Land a run hit on the watchdog's final count.
        guard = 0;
        while (m_since != 46 && guard < 200) begin
            drive(rand_data(), 1'b0);
            guard++;
        end
        check("sim_setup", m_since, 46);
        for (int i = 0; i < 16; i++) drive(rand_tok(), 1'b0);
        drive(rand_data(), 1'b0);
        drive(rand_data(), 1'b0);
        @(posedge clk_pix); #2;
        check("sim_locked", int'(locked), 1);
        check("sim_offset", int'(offset), 0);

        // Data only: lock drops a full watchdog period after that hit.
        for (int i = 0; i < 80; i++) drive(rand_data(), 1'b0);
        @(posedge clk_pix); #2;
        check("loss_locked", int'(locked), 0);
        check("loss_offset", int'(offset), 1);
        check("loss_de", int'(de), 0);

        drive(rand_data(), 1'b1);
        @(posedge clk_pix); #2;
        check("rst_offset", int'(offset), 0);

        // Serial stream with 3 leading junk bits: symbols straddle words at offset 3.
        for (int b = 0; b < 3; b++) sb.push_back(1'($urandom));
        sym_n = 0;
        cyc   = 0;
        while (cyc < 10 * int'(SEARCH_LEN) + 20 && locked !== 1'b1) begin
            while (sb.size() < 10) begin
                s = ((sym_n % 44) < 24) ? rand_tok() : rand_data();
                sym_n++;
                for (int b = 0; b < 10; b++) sb.push_back(s[b]);
            end
            for (int b = 0; b < 10; b++) w[b] = sb.pop_front();
            drive(w, 1'b0);
            cyc++;
        end
        @(posedge clk_pix); #2;
        check("mis_locked", int'(locked), 1);
        check("mis_offset", int'(offset), 3);
        for (int i = 0; i < 60; i++) begin
            while (sb.size() < 10) begin
                s = ((sym_n % 44) < 24) ? rand_tok() : rand_data();
                sym_n++;
                for (int b = 0; b < 10; b++) sb.push_back(s[b]);
            end
            for (int b = 0; b < 10; b++) w[b] = sb.pop_front();
            drive(w, 1'b0);
        end

        repeat (3) @(posedge clk_pix);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
